// File: rtl/tib_loader.sv
// Console input stage: 8N1 serial receiver with minimal line editing that writes accepted
// characters into the terminal input buffer and hands completed lines to the interpreter.
module tib_loader #(
  parameter int unsigned TIB          = 'h1000,
  parameter int unsigned TIB_SZ       = 'h80,
  parameter int unsigned ASZ          = 17,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_i,
  output logic           tib_req_o,
  output logic [ASZ-1:0] tib_addr_o,
  output logic [7:0]     tib_data_o,
  input  logic           tib_ack_i,
  output logic           line_rdy_o,
  output logic [7:0]     line_len_o,
  input  logic           line_ack_i,
  output logic           frm_err_o,
  output logic           drop_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HalfM1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FullM1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CntOne = CW'(1);
  localparam logic [ASZ-1:0] TibBase = ASZ'(TIB);
  localparam logic [7:0]     TibSz = 8'(TIB_SZ);

  typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_e;
  typedef enum logic [1:0] {LAccept, LWrite, LReady} line_state_e;

  // Receiver state
  rx_state_e     rstate_q;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bitn_q;
  logic [7:0]    shift_q;
  logic [7:0]    byte_q;
  logic          stb_q;
  logic          ferr_q;

  // Line editor state
  line_state_e    lstate_q;
  logic [7:0]     idx_q;
  logic           req_q;
  logic [ASZ-1:0] addr_q;
  logic [7:0]     data_q;
  logic           rdy_q;
  logic [7:0]     len_q;
  logic           drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q  <= RIdle;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bitn_q    <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      stb_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      stb_q     <= 1'b0;
      ferr_q    <= 1'b0;
      unique case (rstate_q)
        RIdle: begin
          if (rx_prev_q && !rx_s2_q) begin
            rstate_q <= RStart;
            cnt_q    <= '0;
          end
        end
        RStart: begin
          if (cnt_q == HalfM1) begin
            cnt_q    <= '0;
            bitn_q   <= '0;
            // A line that is high again at mid start bit was only a glitch.
            rstate_q <= rx_s2_q ? RIdle : RData;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        RData: begin
          if (cnt_q == FullM1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s2_q, shift_q[7:1]};
            bitn_q  <= bitn_q + 3'd1;
            if (bitn_q == 3'd7) rstate_q <= RStop;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        RStop: begin
          if (cnt_q == FullM1) begin
            cnt_q    <= '0;
            rstate_q <= RIdle;
            if (rx_s2_q) begin
              stb_q  <= 1'b1;
              byte_q <= shift_q;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: rstate_q <= RIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lstate_q <= LAccept;
      idx_q    <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rdy_q    <= 1'b0;
      len_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      unique case (lstate_q)
        LAccept: begin
          if (stb_q) begin
            if (byte_q == 8'h0D) begin
              len_q    <= idx_q;
              rdy_q    <= 1'b1;
              lstate_q <= LReady;
            end else if (byte_q == 8'h0A) begin
              drop_q <= 1'b0;
            end else if (byte_q == 8'h08 || byte_q == 8'h7F) begin
              if (idx_q != 8'd0) idx_q <= idx_q - 8'd1;
            end else if (idx_q < TibSz) begin
              addr_q   <= TibBase + ASZ'(idx_q);
              data_q   <= byte_q;
              req_q    <= 1'b1;
              lstate_q <= LWrite;
            end else begin
              drop_q <= 1'b1;
            end
          end
        end
        LWrite: begin
          if (stb_q) drop_q <= 1'b1;
          if (tib_ack_i) begin
            req_q    <= 1'b0;
            idx_q    <= idx_q + 8'd1;
            lstate_q <= LAccept;
          end
        end
        LReady: begin
          if (stb_q) drop_q <= 1'b1;
          if (line_ack_i) begin
            rdy_q    <= 1'b0;
            idx_q    <= '0;
            lstate_q <= LAccept;
          end
        end
        default: lstate_q <= LAccept;
      endcase
    end
  end

  assign tib_req_o  = req_q;
  assign tib_addr_o = addr_q;
  assign tib_data_o = data_q;
  assign line_rdy_o = rdy_q;
  assign line_len_o = len_q;
  assign frm_err_o  = ferr_q;
  assign drop_o     = drop_q;

endmodule

// File: tb/tb_tib_loader.sv
// Directed bench for tib_loader: 16 clocks per bit, 4-byte buffer at 'h1000.
module tb_tib_loader;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_i = 1'b1;
  logic        tib_ack_i = 1'b0;
  logic        line_ack_i = 1'b0;
  logic        tib_req_o;
  logic [16:0] tib_addr_o;
  logic [7:0]  tib_data_o;
  logic        line_rdy_o;
  logic [7:0]  line_len_o;
  logic        frm_err_o;
  logic        drop_o;

  int total = 0;
  int bad = 0;

  logic [16:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  int drop_cnt = 0;
  int ferr_cnt = 0;

  tib_loader #(
    .TIB(32'h1000),
    .TIB_SZ(4),
    .ASZ(17),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_i(rx_i),
    .tib_req_o(tib_req_o),
    .tib_addr_o(tib_addr_o),
    .tib_data_o(tib_data_o),
    .tib_ack_i(tib_ack_i),
    .line_rdy_o(line_rdy_o),
    .line_len_o(line_len_o),
    .line_ack_i(line_ack_i),
    .frm_err_o(frm_err_o),
    .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  // Record every accepted write and count output pulses.
  always @(posedge clk) begin
    if (tib_req_o && tib_ack_i) begin
      wr_addr.push_back(tib_addr_o);
      wr_data.push_back(tib_data_o);
    end
    if (drop_o) drop_cnt <= drop_cnt + 1;
    if (frm_err_o) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_clk(CPB);
    end
    rx_i = stop_bit;
    wait_clk(CPB);
    rx_i = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic ack_line;
    line_ack_i = 1'b1;
    wait_clk(1);
    line_ack_i = 1'b0;
    wait_clk(1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_clk(2);
    total++; if (tib_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h want=0", tib_req_o); end
    total++; if (tib_addr_o !== 17'h0) begin bad++; $display("FAIL rst_addr got=%0h want=0", tib_addr_o); end
    total++; if (tib_data_o !== 8'h0) begin bad++; $display("FAIL rst_data got=%0h want=0", tib_data_o); end
    total++; if (line_rdy_o !== 1'b0) begin bad++; $display("FAIL rst_rdy got=%0h want=0", line_rdy_o); end
    total++; if (line_len_o !== 8'h0) begin bad++; $display("FAIL rst_len got=%0h want=0", line_len_o); end
    total++; if (frm_err_o !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%0h want=0", frm_err_o); end
    total++; if (drop_o !== 1'b0) begin bad++; $display("FAIL rst_drop got=%0h want=0", drop_o); end
    rst = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_dup;
    int base;
    logic [7:0] exp_d [3];
    exp_d = '{8'h44, 8'h55, 8'h50};
    tib_ack_i = 1'b1;
    base = wr_addr.size();
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h50); send_byte(8'h0D);
    total++; if (wr_addr.size() != base + 3) begin bad++; $display("FAIL dup_nwr got=%0d want=%0d", wr_addr.size() - base, 3); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (base + i >= wr_addr.size() || wr_addr[base+i] !== 17'h1000 + 17'(i)
          || wr_data[base+i] !== exp_d[i]) begin
        bad++; $display("FAIL dup_wr%0d missing or wrong, want addr=%0h data=%0h", i, 17'h1000 + 17'(i), exp_d[i]);
      end
    end
    total++; if (line_rdy_o !== 1'b1) begin bad++; $display("FAIL dup_rdy got=%0h want=1", line_rdy_o); end
    total++; if (line_len_o !== 8'd3) begin bad++; $display("FAIL dup_len got=%0d want=3", line_len_o); end
    ack_line();
    total++; if (line_rdy_o !== 1'b0) begin bad++; $display("FAIL dup_rdy_ack got=%0h want=0", line_rdy_o); end
    total++; if (line_len_o !== 8'd3) begin bad++; $display("FAIL dup_len_hold got=%0d want=3", line_len_o); end
  endtask

  task automatic test_backspace;
    int base;
    logic [16:0] exp_a [3];
    logic [7:0]  exp_d [3];
    exp_a = '{17'h1000, 17'h1001, 17'h1001};
    exp_d = '{8'h41, 8'h42, 8'h43};
    base = wr_addr.size();
    send_byte(8'h08);
    total++; if (wr_addr.size() != base) begin bad++; $display("FAIL bs_empty_nwr got=%0d want=0", wr_addr.size() - base); end
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h08); send_byte(8'h43); send_byte(8'h0D);
    total++; if (wr_addr.size() != base + 3) begin bad++; $display("FAIL bs_nwr got=%0d want=3", wr_addr.size() - base); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (base + i >= wr_addr.size() || wr_addr[base+i] !== exp_a[i]
          || wr_data[base+i] !== exp_d[i]) begin
        bad++; $display("FAIL bs_wr%0d missing or wrong, want addr=%0h data=%0h", i, exp_a[i], exp_d[i]);
      end
    end
    total++; if (line_len_o !== 8'd2) begin bad++; $display("FAIL bs_len got=%0d want=2", line_len_o); end
    ack_line();
  endtask

  task automatic test_stall;
    int base, d0;
    logic stable;
    tib_ack_i = 1'b0;
    base = wr_addr.size();
    d0 = drop_cnt;
    send_byte(8'h51);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tib_req_o !== 1'b1 || tib_addr_o !== 17'h1000 || tib_data_o !== 8'h51) stable = 1'b0;
      wait_clk(1);
    end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL stall_stable got=%0h want=1", stable); end
    send_byte(8'h52);
    total++; if (drop_cnt - d0 != 1) begin bad++; $display("FAIL stall_drop got=%0d want=1", drop_cnt - d0); end
    total++; if (wr_addr.size() != base) begin bad++; $display("FAIL stall_nowr got=%0d want=0", wr_addr.size() - base); end
    tib_ack_i = 1'b1;
    wait_clk(3);
    total++;
    if (wr_addr.size() != base + 1 || wr_addr[base] !== 17'h1000 || wr_data[base] !== 8'h51) begin
      bad++; $display("FAIL stall_wr got=%0d writes, want one write addr=1000 data=51", wr_addr.size() - base);
    end
    total++; if (tib_req_o !== 1'b0) begin bad++; $display("FAIL stall_req_low got=%0h want=0", tib_req_o); end
    send_byte(8'h0D);
    total++; if (line_len_o !== 8'd1) begin bad++; $display("FAIL stall_len got=%0d want=1", line_len_o); end
    ack_line();
  endtask

  task automatic test_frame_err;
    int base, f0;
    base = wr_addr.size();
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    wait_clk(2 * CPB);
    total++; if (ferr_cnt - f0 != 1) begin bad++; $display("FAIL ferr_pulse got=%0d want=1", ferr_cnt - f0); end
    total++; if (wr_addr.size() != base) begin bad++; $display("FAIL ferr_nowr got=%0d want=0", wr_addr.size() - base); end
    f0 = ferr_cnt;
    rx_i = 1'b0;
    wait_clk(4);
    rx_i = 1'b1;
    wait_clk(40);
    total++; if (wr_addr.size() != base) begin bad++; $display("FAIL glitch_nowr got=%0d want=0", wr_addr.size() - base); end
    total++; if (ferr_cnt != f0) begin bad++; $display("FAIL glitch_ferr got=%0d want=0", ferr_cnt - f0); end
  endtask

  task automatic test_overflow;
    int base, d0;
    base = wr_addr.size();
    d0 = drop_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'h41 + 8'(i));
    send_byte(8'h0D);
    total++; if (wr_addr.size() != base + 4) begin bad++; $display("FAIL ovf_nwr got=%0d want=4", wr_addr.size() - base); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (base + i >= wr_addr.size() || wr_addr[base+i] !== 17'h1000 + 17'(i)
          || wr_data[base+i] !== 8'h41 + 8'(i)) begin
        bad++; $display("FAIL ovf_wr%0d missing or wrong, want addr=%0h data=%0h", i, 17'h1000 + 17'(i), 8'h41 + 8'(i));
      end
    end
    total++; if (drop_cnt - d0 != 1) begin bad++; $display("FAIL ovf_drop got=%0d want=1", drop_cnt - d0); end
    total++; if (line_len_o !== 8'd4) begin bad++; $display("FAIL ovf_len got=%0d want=4", line_len_o); end
    d0 = drop_cnt;
    base = wr_addr.size();
    send_byte(8'h5A);
    total++; if (drop_cnt - d0 != 1) begin bad++; $display("FAIL rdy_drop got=%0d want=1", drop_cnt - d0); end
    total++; if (line_rdy_o !== 1'b1) begin bad++; $display("FAIL rdy_hold got=%0h want=1", line_rdy_o); end
    ack_line();
    send_byte(8'h58);
    total++;
    if (wr_addr.size() != base + 1 || wr_addr[base] !== 17'h1000 || wr_data[base] !== 8'h58) begin
      bad++; $display("FAIL after_ack_wr got=%0d writes, want one write addr=1000 data=58", wr_addr.size() - base);
    end
    send_byte(8'h0D);
    ack_line();
  endtask

  task automatic test_reset_mid;
    int base;
    tib_ack_i = 1'b0;
    send_byte(8'h4B);
    total++; if (tib_req_o !== 1'b1) begin bad++; $display("FAIL rmid_pending got=%0h want=1", tib_req_o); end
    rx_i = 1'b0;
    wait_clk(CPB);
    rx_i = 1'b1;
    wait_clk(CPB / 2);
    rst = 1'b1;
    #1;
    total++; if (tib_req_o !== 1'b0) begin bad++; $display("FAIL rmid_req got=%0h want=0", tib_req_o); end
    total++; if (tib_addr_o !== 17'h0) begin bad++; $display("FAIL rmid_addr got=%0h want=0", tib_addr_o); end
    total++; if (tib_data_o !== 8'h0) begin bad++; $display("FAIL rmid_data got=%0h want=0", tib_data_o); end
    total++; if (line_len_o !== 8'h0) begin bad++; $display("FAIL rmid_len got=%0h want=0", line_len_o); end
    wait_clk(2);
    rx_i = 1'b1;
    rst = 1'b0;
    wait_clk(40);
    base = wr_addr.size();
    tib_ack_i = 1'b1;
    send_byte(8'h4D);
    send_byte(8'h0D);
    total++;
    if (wr_addr.size() != base + 1 || wr_addr[base] !== 17'h1000 || wr_data[base] !== 8'h4D) begin
      bad++; $display("FAIL rmid_wr got=%0d writes, want one write addr=1000 data=4d", wr_addr.size() - base);
    end
    total++; if (line_len_o !== 8'd1) begin bad++; $display("FAIL rmid_rx_len got=%0d want=1", line_len_o); end
    ack_line();
  endtask

  initial begin
    wait_clk(2);
    test_reset();
    test_dup();
    test_backspace();
    test_stall();
    test_frame_err();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
